// File: rtl/mem_arbiter_if.sv
`default_nettype none
// +----------------------------------------------------------------------+
// | Module   : mem_arbiter_if                                            |
// | Purpose  : Requester handshake and shared memory port bundle for the |
// |            two-requester memory arbiter.                             |
// | Revision : 1.0 - initial release                                     |
// +----------------------------------------------------------------------+
interface mem_arbiter_if;
  logic        r0_req;
  logic        r1_req;
  logic        r0_rw;
  logic        r1_rw;
  logic [31:0] r0_addr;
  logic [31:0] r1_addr;
  logic [31:0] r0_wdata;
  logic [31:0] r1_wdata;
  logic        r0_gnt;
  logic        r1_gnt;
  logic        r0_done;
  logic        r1_done;
  logic [31:0] rdata;
  logic        mem_en;
  logic        mem_rw;
  logic [31:0] mem_addr;
  logic [31:0] mem_wdata;
  logic [31:0] mem_rdata;

  // Arbiter side
  modport slave (
    input  r0_req, r1_req, r0_rw, r1_rw, r0_addr, r1_addr,
           r0_wdata, r1_wdata, mem_rdata,
    output r0_gnt, r1_gnt, r0_done, r1_done, rdata,
           mem_en, mem_rw, mem_addr, mem_wdata
  );

  // Requester / memory model side
  modport master (
    output r0_req, r1_req, r0_rw, r1_rw, r0_addr, r1_addr,
           r0_wdata, r1_wdata, mem_rdata,
    input  r0_gnt, r1_gnt, r0_done, r1_done, rdata,
           mem_en, mem_rw, mem_addr, mem_wdata
  );
endinterface
`default_nettype wire

// File: rtl/mem_arbiter.sv
`default_nettype none
// +----------------------------------------------------------------------+
// | Module   : mem_arbiter                                               |
// | Purpose  : Two-requester arbiter onto one shared memory R/W port.    |
// |            IDLE -> ACCESS (WAIT_CYCLES) -> DONE (one-cycle pulse).   |
// | Options  : ARB_ROUND_ROBIN_EN - alternate ties between requesters;   |
// |            undefined gives fixed priority to requester 0.            |
// | Revision : 1.0 - initial release                                     |
// +----------------------------------------------------------------------+
module mem_arbiter #(
  parameter int WAIT_CYCLES = 1
) (
  input  wire logic     clk,
  input  wire logic     reset,
  mem_arbiter_if.slave  bus
);

  localparam logic [3:0] c_LAST = 4'(WAIT_CYCLES - 1);

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    ACCESS = 2'd1,
    DONE   = 2'd2
  } state_t;

  state_t      state_q, state_d;
  logic [3:0]  cnt_q, cnt_d;
  logic        sel_q, sel_d;      // 0 = requester 0, 1 = requester 1
  logic        rw_q, rw_d;
  logic [31:0] addr_q, addr_d;
  logic [31:0] wdata_q, wdata_d;
  logic [31:0] rdata_q, rdata_d;
  logic        w_pick;

`ifdef ARB_ROUND_ROBIN_EN
  logic last_q, last_d;

  // On a tie, serve whoever was not served last
  always_comb begin
    if (bus.r0_req && bus.r1_req) w_pick = ~last_q;
    else                          w_pick = ~bus.r0_req;
  end

  // Last-served pointer; reset points at requester 1 so requester 0 wins first
  always_ff @(posedge clk) begin
    if (reset) last_q <= 1'b1;
    else       last_q <= last_d;
  end

  // Pointer moves when a transaction is issued
  always_comb begin
    last_d = last_q;
    if (state_q == IDLE && (bus.r0_req || bus.r1_req)) last_d = w_pick;
  end
`else
  // Fixed priority: requester 0 wins whenever it asks
  always_comb w_pick = ~bus.r0_req;
`endif

  // State and latched transaction registers
  always_ff @(posedge clk) begin
    if (reset) begin
      state_q <= IDLE;
      cnt_q   <= 4'd0;
      sel_q   <= 1'b0;
      rw_q    <= 1'b0;
      addr_q  <= 32'd0;
      wdata_q <= 32'd0;
      rdata_q <= 32'd0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      sel_q   <= sel_d;
      rw_q    <= rw_d;
      addr_q  <= addr_d;
      wdata_q <= wdata_d;
      rdata_q <= rdata_d;
    end
  end

  // Next-state: latch the winner in IDLE, count ACCESS cycles, pulse in DONE
  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    sel_d   = sel_q;
    rw_d    = rw_q;
    addr_d  = addr_q;
    wdata_d = wdata_q;
    rdata_d = rdata_q;
    case (state_q)
      IDLE: begin
        if (bus.r0_req || bus.r1_req) begin
          sel_d   = w_pick;
          rw_d    = w_pick ? bus.r1_rw    : bus.r0_rw;
          addr_d  = w_pick ? bus.r1_addr  : bus.r0_addr;
          wdata_d = w_pick ? bus.r1_wdata : bus.r0_wdata;
          cnt_d   = 4'd0;
          state_d = ACCESS;
        end
      end
      ACCESS: begin
        if (cnt_q == c_LAST) begin
          if (!rw_q) rdata_d = bus.mem_rdata;
          state_d = DONE;
        end else begin
          cnt_d = cnt_q + 4'd1;
        end
      end
      DONE:    state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  // Memory port drives the latched fields, which hold outside ACCESS
  assign bus.mem_en    = (state_q == ACCESS);
  assign bus.mem_rw    = rw_q;
  assign bus.mem_addr  = addr_q;
  assign bus.mem_wdata = wdata_q;
  assign bus.r0_gnt    = (state_q == ACCESS) && !sel_q;
  assign bus.r1_gnt    = (state_q == ACCESS) &&  sel_q;
  assign bus.r0_done   = (state_q == DONE)   && !sel_q;
  assign bus.r1_done   = (state_q == DONE)   &&  sel_q;
  assign bus.rdata     = rdata_q;

endmodule
`default_nettype wire

// File: tb/tb_mem_arbiter.sv
`default_nettype none
// +----------------------------------------------------------------------+
// | Module   : tb_mem_arbiter                                            |
// | Purpose  : Directed self-checking bench for mem_arbiter, one DUT     |
// |            with WAIT_CYCLES=1 and one with WAIT_CYCLES=3.            |
// | Revision : 1.0 - initial release                                     |
// +----------------------------------------------------------------------+
module tb_mem_arbiter;
  logic clk;
  logic reset;
  int   checks;
  int   errors;

  mem_arbiter_if b1 ();
  mem_arbiter_if b3 ();

  mem_arbiter #(.WAIT_CYCLES(1)) u_dut1 (.clk(clk), .reset(reset), .bus(b1));
  mem_arbiter #(.WAIT_CYCLES(3)) u_dut3 (.clk(clk), .reset(reset), .bus(b3));

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Advance one cycle; outputs are observed and inputs changed 1 time unit after the edge
  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic test_reset();
    reset = 1'b1;
    tick();
    tick();
    reset = 1'b0;
    checks++; if (b1.r0_gnt !== 1'b0 || b1.r1_gnt !== 1'b0) begin errors++; $display("FAIL rst_gnt: got %b%b want 00", b1.r0_gnt, b1.r1_gnt); end
    checks++; if (b1.r0_done !== 1'b0 || b1.r1_done !== 1'b0) begin errors++; $display("FAIL rst_done: got %b%b want 00", b1.r0_done, b1.r1_done); end
    checks++; if (b1.mem_en !== 1'b0 || b1.mem_rw !== 1'b0) begin errors++; $display("FAIL rst_mem: en=%b rw=%b want 0 0", b1.mem_en, b1.mem_rw); end
    checks++; if (b1.mem_addr !== 32'd0 || b1.mem_wdata !== 32'd0 || b1.rdata !== 32'd0) begin errors++; $display("FAIL rst_data: addr=%h wdata=%h rdata=%h want 0", b1.mem_addr, b1.mem_wdata, b1.rdata); end
  endtask

  task automatic test_single_read();
    b1.r0_req = 1'b1; b1.r0_rw = 1'b0; b1.r0_addr = 32'h0000_1000; b1.mem_rdata = 32'hDEAD_BEEF;
    tick();                      // ACCESS
    b1.r0_req = 1'b0;
    checks++; if (b1.mem_en !== 1'b1 || b1.r0_gnt !== 1'b1 || b1.r1_gnt !== 1'b0) begin errors++; $display("FAIL rd_access: en=%b g0=%b g1=%b want 1 1 0", b1.mem_en, b1.r0_gnt, b1.r1_gnt); end
    checks++; if (b1.mem_addr !== 32'h0000_1000 || b1.mem_rw !== 1'b0) begin errors++; $display("FAIL rd_addr: addr=%h rw=%b want 00001000 0", b1.mem_addr, b1.mem_rw); end
    tick();                      // DONE, two cycles after req sampled
    checks++; if (b1.r0_done !== 1'b1 || b1.r1_done !== 1'b0 || b1.mem_en !== 1'b0) begin errors++; $display("FAIL rd_done: d0=%b d1=%b en=%b want 1 0 0", b1.r0_done, b1.r1_done, b1.mem_en); end
    checks++; if (b1.rdata !== 32'hDEAD_BEEF) begin errors++; $display("FAIL rd_data: got %h want deadbeef", b1.rdata); end
    tick();
    checks++; if (b1.r0_done !== 1'b0) begin errors++; $display("FAIL rd_pulse: got %b want 0", b1.r0_done); end
  endtask

  task automatic test_single_write();
    b1.r1_req = 1'b1; b1.r1_rw = 1'b1; b1.r1_addr = 32'h0000_2000; b1.r1_wdata = 32'h1234_5678;
    b1.mem_rdata = 32'hCAFE_F00D;
    tick();                      // ACCESS
    b1.r1_req = 1'b0;
    checks++; if (b1.mem_en !== 1'b1 || b1.r1_gnt !== 1'b1 || b1.r0_gnt !== 1'b0) begin errors++; $display("FAIL wr_access: en=%b g0=%b g1=%b want 1 0 1", b1.mem_en, b1.r0_gnt, b1.r1_gnt); end
    checks++; if (b1.mem_rw !== 1'b1 || b1.mem_addr !== 32'h0000_2000 || b1.mem_wdata !== 32'h1234_5678) begin errors++; $display("FAIL wr_bus: rw=%b addr=%h wdata=%h want 1 00002000 12345678", b1.mem_rw, b1.mem_addr, b1.mem_wdata); end
    tick();                      // DONE
    checks++; if (b1.r1_done !== 1'b1 || b1.r0_done !== 1'b0 || b1.mem_en !== 1'b0) begin errors++; $display("FAIL wr_done: d0=%b d1=%b en=%b want 0 1 0", b1.r0_done, b1.r1_done, b1.mem_en); end
    checks++; if (b1.rdata !== 32'hDEAD_BEEF) begin errors++; $display("FAIL wr_rdata_kept: got %h want deadbeef", b1.rdata); end
    checks++; if (b1.mem_addr !== 32'h0000_2000 || b1.mem_wdata !== 32'h1234_5678) begin errors++; $display("FAIL wr_hold: addr=%h wdata=%h want 00002000 12345678", b1.mem_addr, b1.mem_wdata); end
    tick();
  endtask

  task automatic test_contention();
    logic exp_sel;
    b1.r0_req = 1'b1; b1.r0_rw = 1'b0; b1.r0_addr = 32'h0000_00A0;
    b1.r1_req = 1'b1; b1.r1_rw = 1'b0; b1.r1_addr = 32'h0000_00B0;
    for (int k = 0; k < 4; k++) begin
`ifdef ARB_ROUND_ROBIN_EN
      exp_sel = k[0];            // last served was r1 (write test): r0,r1,r0,r1
`else
      exp_sel = 1'b0;            // fixed priority: r0 every time
`endif
      tick();                    // ACCESS
      checks++; if (b1.r0_gnt !== !exp_sel || b1.r1_gnt !== exp_sel) begin errors++; $display("FAIL cont_gnt[%0d]: g0=%b g1=%b want %b %b", k, b1.r0_gnt, b1.r1_gnt, !exp_sel, exp_sel); end
      checks++; if (b1.mem_addr !== (exp_sel ? 32'h0000_00B0 : 32'h0000_00A0)) begin errors++; $display("FAIL cont_addr[%0d]: got %h want %h", k, b1.mem_addr, exp_sel ? 32'h0000_00B0 : 32'h0000_00A0); end
      tick();                    // DONE
      checks++; if (b1.r0_done !== !exp_sel || b1.r1_done !== exp_sel) begin errors++; $display("FAIL cont_done[%0d]: d0=%b d1=%b want %b %b", k, b1.r0_done, b1.r1_done, !exp_sel, exp_sel); end
      tick();                    // IDLE, requests still held
      if (k == 3) begin
        b1.r0_req = 1'b0;
        b1.r1_req = 1'b0;
      end
    end
    tick();
    checks++; if (b1.mem_en !== 1'b0) begin errors++; $display("FAIL cont_quiet: en=%b want 0", b1.mem_en); end
  endtask

  task automatic test_wait3();
    b3.r0_req = 1'b1; b3.r0_rw = 1'b0; b3.r0_addr = 32'h0000_0100; b3.mem_rdata = 32'h1111_1111;
    tick();                      // ACCESS cycle 1
    b3.r0_req = 1'b0; b3.r0_addr = 32'h0000_0BAD; b3.r0_rw = 1'b1;
    for (int c = 1; c <= 3; c++) begin
      checks++; if (b3.mem_en !== 1'b1 || b3.r0_gnt !== 1'b1 || b3.r0_done !== 1'b0) begin errors++; $display("FAIL w3_access[%0d]: en=%b g0=%b d0=%b want 1 1 0", c, b3.mem_en, b3.r0_gnt, b3.r0_done); end
      checks++; if (b3.mem_addr !== 32'h0000_0100 || b3.mem_rw !== 1'b0) begin errors++; $display("FAIL w3_frozen[%0d]: addr=%h rw=%b want 00000100 0", c, b3.mem_addr, b3.mem_rw); end
      if (c == 3) b3.mem_rdata = 32'h55AA_55AA;   // valid only in the last ACCESS cycle
      tick();
    end
    // DONE: four cycles after the request was sampled
    checks++; if (b3.r0_done !== 1'b1 || b3.mem_en !== 1'b0) begin errors++; $display("FAIL w3_done: d0=%b en=%b want 1 0", b3.r0_done, b3.mem_en); end
    checks++; if (b3.rdata !== 32'h55AA_55AA) begin errors++; $display("FAIL w3_rdata: got %h want 55aa55aa", b3.rdata); end
    tick();
    checks++; if (b3.r0_done !== 1'b0 || b3.mem_en !== 1'b0) begin errors++; $display("FAIL w3_once: d0=%b en=%b want 0 0", b3.r0_done, b3.mem_en); end
  endtask

  task automatic test_reset_mid();
    b3.r1_req = 1'b1; b3.r1_rw = 1'b1; b3.r1_addr = 32'h0000_0300; b3.r1_wdata = 32'hA5A5_A5A5;
    tick();                      // ACCESS cycle 1
    tick();                      // ACCESS cycle 2
    checks++; if (b3.mem_en !== 1'b1 || b3.r1_gnt !== 1'b1) begin errors++; $display("FAIL rm_access: en=%b g1=%b want 1 1", b3.mem_en, b3.r1_gnt); end
    reset = 1'b1; b3.r1_req = 1'b0;
    tick();
    reset = 1'b0;
    checks++; if (b3.mem_en !== 1'b0 || b3.r0_gnt !== 1'b0 || b3.r1_gnt !== 1'b0 || b3.r0_done !== 1'b0 || b3.r1_done !== 1'b0) begin errors++; $display("FAIL rm_ctrl: en=%b g=%b%b d=%b%b want 0", b3.mem_en, b3.r0_gnt, b3.r1_gnt, b3.r0_done, b3.r1_done); end
    checks++; if (b3.mem_rw !== 1'b0 || b3.mem_addr !== 32'd0 || b3.mem_wdata !== 32'd0 || b3.rdata !== 32'd0) begin errors++; $display("FAIL rm_data: rw=%b addr=%h wdata=%h rdata=%h want 0", b3.mem_rw, b3.mem_addr, b3.mem_wdata, b3.rdata); end
    tick();
    checks++; if (b3.r1_done !== 1'b0 || b3.mem_en !== 1'b0) begin errors++; $display("FAIL rm_nodone: d1=%b en=%b want 0 0", b3.r1_done, b3.mem_en); end
    b3.r0_req = 1'b1; b3.r0_rw = 1'b0; b3.r0_addr = 32'h0000_0400;
    b3.r1_req = 1'b1; b3.r1_rw = 1'b0; b3.r1_addr = 32'h0000_0500;
    tick();
    b3.r0_req = 1'b0; b3.r1_req = 1'b0;
    checks++; if (b3.r0_gnt !== 1'b1 || b3.r1_gnt !== 1'b0 || b3.mem_addr !== 32'h0000_0400) begin errors++; $display("FAIL rm_tie: g0=%b g1=%b addr=%h want 1 0 00000400", b3.r0_gnt, b3.r1_gnt, b3.mem_addr); end
    for (int i = 0; i < 4; i++) tick();
  endtask

  initial begin
    checks = 0;
    errors = 0;
    reset  = 1'b1;
    b1.r0_req = 1'b0; b1.r1_req = 1'b0; b1.r0_rw = 1'b0; b1.r1_rw = 1'b0;
    b1.r0_addr = 32'd0; b1.r1_addr = 32'd0; b1.r0_wdata = 32'd0; b1.r1_wdata = 32'd0;
    b1.mem_rdata = 32'd0;
    b3.r0_req = 1'b0; b3.r1_req = 1'b0; b3.r0_rw = 1'b0; b3.r1_rw = 1'b0;
    b3.r0_addr = 32'd0; b3.r1_addr = 32'd0; b3.r0_wdata = 32'd0; b3.r1_wdata = 32'd0;
    b3.mem_rdata = 32'd0;
    test_reset();
    test_single_read();
    test_single_write();
    test_contention();
    test_wait3();
    test_reset_mid();
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end
endmodule
`default_nettype wire

// File: doc/mem_arbiter.md
MEM_ARBITER -- requirements
Module: mem_arbiter

Interface
REQ-001 SHALL have parameter WAIT_CYCLES, default 1: memory access cycles per transaction, legal range 1..15.
REQ-002 SHALL have port clk, input, 1: single clock; all state updates on its rising edge.
REQ-003 SHALL have port reset, input, 1: reset is synchronous and active-high.
REQ-004 SHALL have ports r0_req/r1_req, input, 1 each: access request from requester 0 (core operand port) and requester 1 (loader/debug).
REQ-005 SHALL have ports r0_rw/r1_rw, input, 1 each: 1 = write, 0 = read.
REQ-006 SHALL have ports r0_addr/r1_addr and r0_wdata/r1_wdata, input, 32 each: address and write data.
REQ-007 SHALL have ports r0_gnt/r1_gnt, output, 1 each: requester owns the memory port.
REQ-008 SHALL have ports r0_done/r1_done, output, 1 each: one-cycle completion pulse.
REQ-009 SHALL have port rdata, output, 32: read data, valid while any done is high.
REQ-010 SHALL have ports mem_en, mem_rw (output, 1), mem_addr, mem_wdata (output, 32), and mem_rdata (input, 32): the shared memory R/W port.

Function
REQ-011 SHALL implement FSM states IDLE, ACCESS, DONE.
REQ-012 In IDLE with any req high, the arbiter SHALL select one requester, latch its rw/addr/wdata, and enter ACCESS on the next edge.
REQ-013 In ACCESS, the arbiter SHALL assert mem_en and the selected gnt and drive the latched rw/addr/wdata for exactly WAIT_CYCLES cycles, counted by a 4-bit counter.
REQ-014 On the last ACCESS cycle, the arbiter SHALL capture mem_rdata into rdata if rw=0 and leave rdata unchanged if rw=1.
REQ-015 In DONE, the arbiter SHALL deassert mem_en and gnt, pulse the selected done for one cycle, then return to IDLE.
REQ-016 Latency from req sampled in IDLE to done SHALL be WAIT_CYCLES+1 cycles, and the minimum back-to-back issue interval SHALL be WAIT_CYCLES+2 cycles.
REQ-017 Latched request fields SHALL be frozen during ACCESS, so input changes mid-transaction SHALL have no effect.
REQ-018 If req drops during ACCESS, the transaction SHALL still complete and done SHALL still pulse.
REQ-019 gnt SHALL never be high for both requesters, and done SHALL never be high for both requesters.
REQ-020 mem_en SHALL be 0, and mem_addr/mem_wdata SHALL hold their last values, outside ACCESS.
REQ-021 A requester still holding req in the DONE cycle SHALL be eligible for arbitration again in the following IDLE cycle.

Reset
REQ-022 With reset high at a clock edge, the FSM SHALL go to IDLE, and gnt, done, mem_en, mem_rw, mem_addr, mem_wdata, and rdata SHALL go to 0.
REQ-023 Reset mid-ACCESS SHALL abort the transaction with no done pulse; the memory write SHALL NOT be retried.
REQ-024 Reset SHALL set the last-served pointer to requester 1, so requester 0 wins the first tie.

Configuration
REQ-025 With ARB_ROUND_ROBIN_EN defined, simultaneous requests SHALL be granted to the requester not served last, and the last-served pointer SHALL update on entering ACCESS.
REQ-026 Without ARB_ROUND_ROBIN_EN, requester 0 SHALL always win ties (fixed priority), and the pointer logic SHALL be absent.

Verification (WAIT_CYCLES=1 unless noted)
REQ-027 Scenario, single read: r0 read at addr 0x1000, mem_rdata=0xDEADBEEF -> mem_en high for 1 cycle, r0_done pulses 2 cycles after req is sampled, rdata=0xDEADBEEF.
REQ-028 Scenario, single write: r1 write of 0x12345678 to 0x2000 -> mem_rw=1, mem_addr=0x2000, mem_wdata=0x12345678 for 1 cycle, then r1_done pulses; rdata unchanged.
REQ-029 Scenario, contention: both req held for 4 transactions -> with macro, grants are r0,r1,r0,r1; without macro, grants are r0,r0,r0,r0.
REQ-030 Scenario, WAIT_CYCLES=3 with r0_addr changed mid-ACCESS -> mem_en high for 3 cycles, mem_addr stays at the latched value, done arrives 4 cycles after req is sampled.
REQ-031 Scenario, reset asserted in the second ACCESS cycle -> no done pulse, all outputs are 0 on the next cycle, and the first subsequent tie is granted to r0.
REQ-032 Scenario, req dropped after the first ACCESS cycle -> transaction completes and done still pulses once.
